// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_arb_pkg
// Purpose  : Shared types and the round-robin pick helper for the cache
//            arbiter (and any future arbiter built on the same scheme).
// Contents : arb_state_t - arbiter FSM states
//            grant_t     - which requester owns (or last owned) the port
//            rr_pick()   - two-requester round-robin select
// Revision : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DRAIN   = 2'd3
  } arb_state_t;

  typedef enum logic [0:0] {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // On a tie the requester that did not win last time is chosen. With a
  // single requester that one wins; the caller decides whether anyone is
  // requesting at all.
  function automatic grant_t rr_pick(input logic i_req, input logic d_req,
                                     input grant_t last_grant);
    if (i_req && d_req) return (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    return i_req ? GRANT_I : GRANT_D;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Purpose  : Shares the cacheline adaptor port between the I-cache (read
//            only) and the D-cache (read / write-back). One requester is
//            granted at a time, round-robin on ties, and the grant is held
//            until the adaptor has dropped its response.
// Ports    : clk, reset_n              - clock, async active-low reset
//            i_read/i_address          - I-cache request
//            i_line_o/i_resp           - I-cache fill line / completion pulse
//            d_read/d_write/d_address  - D-cache request
//            d_line_i                  - D-cache write-back line
//            d_line_o/d_resp           - D-cache fill line / completion pulse
//            mem_*                     - adaptor command / data / response
// Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_line_i,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_line_o,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              mem_resp
);

  arb_state_t          r_state;
  grant_t              r_last_grant;
  logic [LINE_W-1:0]   r_i_line;
  logic [LINE_W-1:0]   r_d_line;
  logic                w_d_req;
  grant_t              w_pick;

  assign w_d_req = d_read | d_write;
  assign w_pick  = rr_pick(i_read, w_d_req, r_last_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_D;
      r_i_line     <= '0;
      r_d_line     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_read || w_d_req)
            r_state <= (w_pick == GRANT_I) ? SERVE_I : SERVE_D;
        end
        SERVE_I: begin
          if (mem_resp) begin
            r_i_line     <= mem_line_i;
            r_last_grant <= GRANT_I;
            r_state      <= DRAIN;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            // Write-backs return no data, so the held fill line survives.
            if (d_read) r_d_line <= mem_line_i;
            r_last_grant <= GRANT_D;
            r_state      <= DRAIN;
          end
        end
        DRAIN: begin
          // The adaptor may hold resp for several cycles; wait it out so
          // the next command never overlaps a stale response.
          if (!mem_resp) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Command side depends only on state and the held request, never on
  // mem_resp. Completion pulses are the first resp cycle of the grant,
  // since the FSM leaves SERVE_* on that same edge.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_line_o  = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (r_state)
      SERVE_I: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        i_resp      = mem_resp;
      end
      SERVE_D: begin
        mem_read    = d_read;
        mem_write   = d_write & ~d_read;
        mem_address = d_address;
        mem_line_o  = d_line_i;
        d_resp      = mem_resp;
      end
      default: ;
    endcase
  end

  // Lines are visible in the resp cycle itself, then held by the register.
  assign i_line_o = i_resp ? mem_line_i : r_i_line;
  assign d_line_o = (d_resp && d_read) ? mem_line_i : r_d_line;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Purpose  : Self-checking bench for cache_arbiter: a per-cycle vector table
//            for single transactions, then directed sequences for
//            round-robin alternation, reset mid-transaction and a long
//            adaptor response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

  localparam int  ADDR_W = 32;
  localparam int  LINE_W = 256;
  localparam bit  T = 1'b1;
  localparam bit  F = 1'b0;
  localparam logic [LINE_W-1:0] L_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] L_D1 = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] L_5A = {32{8'h5A}};
  localparam logic [LINE_W-1:0] L_0  = '0;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_line_o;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_line_i = '0;
  logic [LINE_W-1:0] d_line_o;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_line_o;
  logic [LINE_W-1:0] mem_line_i = '0;
  logic              mem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_address(i_address), .i_line_o(i_line_o), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_line_i(d_line_i), .d_line_o(d_line_o), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_line_o(mem_line_o), .mem_line_i(mem_line_i), .mem_resp(mem_resp)
  );

  typedef struct {
    // stimulus
    logic ir; logic [ADDR_W-1:0] ia;
    logic dr; logic dw; logic [ADDR_W-1:0] da; logic [LINE_W-1:0] dl;
    logic mr; logic [LINE_W-1:0] ml;
    // expected outputs in the same cycle
    logic e_mrd; logic e_mwr; logic [ADDR_W-1:0] e_ma; logic [LINE_W-1:0] e_mlo;
    logic e_ir; logic e_dr; logic [LINE_W-1:0] e_il; logic [LINE_W-1:0] e_dl;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_line_i = '0; mem_resp = 1'b0; mem_line_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Counts command-free negedges until a command shows; bounded.
  task automatic wait_cmd(output int gap, output bit ok);
    gap = 0;
    ok  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (mem_read || mem_write) begin
        ok = 1'b1;
        break;
      end
      gap++;
    end
  endtask

  initial begin
    int gap;
    bit ok;
    int ipulses, dpulses, cmds;
    logic [LINE_W-1:0] lk;

    //           ir ia        dr dw da        dl    mr ml     mrd mwr ma       mlo   ir dr il    dl
    vecs[0]  = '{T, 32'h1000, F, F, 32'h0,    L_0,  F, L_0,   F, F, 32'h0,    L_0,  F, F, L_0,  L_0};
    vecs[1]  = '{T, 32'h1000, F, F, 32'h0,    L_0,  F, L_0,   T, F, 32'h1000, L_0,  F, F, L_0,  L_0};
    vecs[2]  = '{T, 32'h1000, F, F, 32'h0,    L_0,  T, L_A5,  T, F, 32'h1000, L_0,  T, F, L_A5, L_0};
    vecs[3]  = '{F, 32'h1000, F, F, 32'h0,    L_0,  T, L_A5,  F, F, 32'h0,    L_0,  F, F, L_A5, L_0};
    vecs[4]  = '{F, 32'h1000, F, F, 32'h0,    L_0,  T, L_A5,  F, F, 32'h0,    L_0,  F, F, L_A5, L_0};
    vecs[5]  = '{F, 32'h0,    F, F, 32'h0,    L_0,  F, L_0,   F, F, 32'h0,    L_0,  F, F, L_A5, L_0};
    vecs[6]  = '{F, 32'h0,    F, T, 32'h2040, L_D1, F, L_0,   F, F, 32'h0,    L_0,  F, F, L_A5, L_0};
    vecs[7]  = '{F, 32'h0,    F, T, 32'h2040, L_D1, F, L_0,   F, T, 32'h2040, L_D1, F, F, L_A5, L_0};
    vecs[8]  = '{F, 32'h0,    F, T, 32'h2040, L_D1, T, L_5A,  F, T, 32'h2040, L_D1, F, T, L_A5, L_0};
    vecs[9]  = '{F, 32'h0,    F, F, 32'h0,    L_0,  F, L_0,   F, F, 32'h0,    L_0,  F, F, L_A5, L_0};
    vecs[10] = '{F, 32'h0,    T, F, 32'h2080, L_0,  F, L_0,   F, F, 32'h0,    L_0,  F, F, L_A5, L_0};
    vecs[11] = '{F, 32'h0,    T, T, 32'h2080, L_0,  F, L_0,   T, F, 32'h2080, L_0,  F, F, L_A5, L_0};
    vecs[12] = '{F, 32'h0,    T, F, 32'h2080, L_0,  T, L_5A,  T, F, 32'h2080, L_0,  F, T, L_A5, L_5A};
    vecs[13] = '{F, 32'h0,    F, F, 32'h0,    L_0,  F, L_0,   F, F, 32'h0,    L_0,  F, F, L_A5, L_5A};

    // Reset state
    #1;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_i_line", i_line_o, L_0);
    chk("rst_d_line", d_line_o, L_0);
    do_reset();

    // Table: one vector per cycle, driven at negedge, checked 1 ns later
    for (int v = 0; v < 14; v++) begin
      if (v != 0) @(negedge clk);
      i_read = vecs[v].ir; i_address = vecs[v].ia;
      d_read = vecs[v].dr; d_write = vecs[v].dw; d_address = vecs[v].da;
      d_line_i = vecs[v].dl; mem_resp = vecs[v].mr; mem_line_i = vecs[v].ml;
      #1;
      chk($sformatf("v%0d_mem_read", v), mem_read, vecs[v].e_mrd);
      chk($sformatf("v%0d_mem_write", v), mem_write, vecs[v].e_mwr);
      chk($sformatf("v%0d_mem_address", v), mem_address, vecs[v].e_ma);
      chk($sformatf("v%0d_mem_line_o", v), mem_line_o, vecs[v].e_mlo);
      chk($sformatf("v%0d_i_resp", v), i_resp, vecs[v].e_ir);
      chk($sformatf("v%0d_d_resp", v), d_resp, vecs[v].e_dr);
      chk($sformatf("v%0d_i_line_o", v), i_line_o, vecs[v].e_il);
      chk($sformatf("v%0d_d_line_o", v), d_line_o, vecs[v].e_dl);
    end

    // Round-robin: both held continuously, expect I,D,I,D,I,D
    do_reset();
    i_read = 1'b1; i_address = 32'h3000;
    d_read = 1'b1; d_address = 32'h3100;
    for (int k = 0; k < 6; k++) begin
      bit exp_d;
      exp_d = (k % 2) == 1;
      lk = {8{32'hC0DE_0000 | 32'(k)}};
      wait_cmd(gap, ok);
      chk($sformatf("rr%0d_timeout", k), ok, 1'b1);
      if (k > 0) chk($sformatf("rr%0d_gap", k), gap, 1);
      chk($sformatf("rr%0d_address", k), mem_address, exp_d ? 32'h3100 : 32'h3000);
      chk($sformatf("rr%0d_mem_read", k), mem_read, 1'b1);
      mem_resp = 1'b1; mem_line_i = lk;
      #1;
      chk($sformatf("rr%0d_i_resp", k), i_resp, !exp_d);
      chk($sformatf("rr%0d_d_resp", k), d_resp, exp_d);
      if (exp_d) chk($sformatf("rr%0d_d_line", k), d_line_o, lk);
      else       chk($sformatf("rr%0d_i_line", k), i_line_o, lk);
      @(negedge clk);
      mem_resp = 1'b0; mem_line_i = '0;
      if (k == 5) i_read = 1'b0;
      #1;
      chk($sformatf("rr%0d_drain_cmd", k), mem_read | mem_write, 1'b0);
      chk($sformatf("rr%0d_drain_resp", k), i_resp | d_resp, 1'b0);
    end

    // Reset in the middle of SERVE_D; line registers hold nonzero data here
    d_address = 32'h4000;
    wait_cmd(gap, ok);
    chk("mid_rst_timeout", ok, 1'b1);
    chk("mid_rst_address", mem_address, 32'h4000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_read", mem_read, 1'b0);
    chk("mid_rst_mem_address", mem_address, 32'h0);
    chk("mid_rst_i_line", i_line_o, L_0);
    chk("mid_rst_d_line", d_line_o, L_0);
    mem_resp = 1'b1; mem_line_i = L_5A;
    #1;
    chk("mid_rst_d_resp", d_resp, 1'b0);
    repeat (2) @(negedge clk);
    clear_inputs();
    i_read = 1'b1; i_address = 32'h5000;
    reset_n = 1'b1;
    wait_cmd(gap, ok);
    chk("post_rst_timeout", ok, 1'b1);
    chk("post_rst_address", mem_address, 32'h5000);
    mem_resp = 1'b1; mem_line_i = L_A5;
    #1;
    chk("post_rst_i_resp", i_resp, 1'b1);
    chk("post_rst_i_line", i_line_o, L_A5);
    @(negedge clk);
    i_read = 1'b0; mem_resp = 1'b0;

    // mem_resp held for 10 cycles with the D write-back pending
    do_reset();
    i_read = 1'b1; i_address = 32'h6000;
    d_write = 1'b1; d_address = 32'h7000; d_line_i = L_D1;
    wait_cmd(gap, ok);
    chk("long_timeout", ok, 1'b1);
    chk("long_first_is_i", mem_address, 32'h6000);
    ipulses = 0; dpulses = 0; cmds = 0;
    mem_resp = 1'b1; mem_line_i = L_A5;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) begin
        @(negedge clk);
        i_read = 1'b0;
      end
      #1;
      if (i_resp) ipulses++;
      if (d_resp) dpulses++;
      if (c != 0 && (mem_read || mem_write)) cmds++;
    end
    chk("long_i_pulses", ipulses, 1);
    chk("long_d_pulses", dpulses, 0);
    chk("long_cmds_in_drain", cmds, 0);
    @(negedge clk);
    mem_resp = 1'b0; mem_line_i = '0;
    #1;
    chk("long_drain_cmd", mem_read | mem_write, 1'b0);
    wait_cmd(gap, ok);
    chk("long_d_timeout", ok, 1'b1);
    chk("long_d_gap", gap, 1);
    chk("long_d_mem_write", mem_write, 1'b1);
    chk("long_d_address", mem_address, 32'h7000);
    chk("long_d_line_o", mem_line_o, L_D1);
    mem_resp = 1'b1; mem_line_i = L_5A;
    #1;
    chk("long_d_resp", d_resp, 1'b1);
    chk("long_d_line_kept", d_line_o, L_0);
    @(negedge clk);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
